// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register slave: write and read FSM states.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle without WSTRB/BRESP/RRESP/PROT.
// Channels: AW (AWVALID/AWREADY/AWADDR), W (WVALID/WREADY/WDATA),
// B (BVALID/BREADY), AR (ARVALID/ARREADY/ARADDR), R (RVALID/RREADY/RDATA).
interface axi4_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic              WVALID;
  logic              WREADY;
  logic [DATA_W-1:0] WDATA;
  logic              BVALID;
  logic              BREADY;
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;

  modport slave (
    input  AWVALID, AWADDR, WVALID, WDATA, BREADY, ARVALID, ARADDR, RREADY,
    output AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA
  );

  modport master (
    output AWVALID, AWADDR, WVALID, WDATA, BREADY, ARVALID, ARADDR, RREADY,
    input  AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA
  );

endinterface

// File: rtl/axi4_lite_reg_bank.sv
// Register array with one write port and a combinational read port.
// Ports: clk, rst_n (sync, active-low), we/widx/wdata (write port),
// ridx/rdata (read port), regs_o (flattened contents), wr_stb_o (one-hot
// pulse in the cycle after a write, marking the register written).
module axi4_lite_reg_bank #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 16,
  parameter int IDX_W  = $clog2(REG_N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IDX_W-1:0]        widx,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [IDX_W-1:0]        ridx,
  output logic [DATA_W-1:0]       rdata,
  output logic [REG_N*DATA_W-1:0] regs_o,
  output logic [REG_N-1:0]        wr_stb_o
);

  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] regs_d [REG_N];
  logic [REG_N-1:0]  wr_stb_q, wr_stb_d;

  always_comb begin
    regs_d   = regs_q;
    wr_stb_d = '0;
    if (we) begin
      regs_d[widx]   = wdata;
      wr_stb_d[widx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q   <= '{default: '0};
      wr_stb_q <= '0;
    end else begin
      regs_q   <= regs_d;
      wr_stb_q <= wr_stb_d;
    end
  end

  // Read sees the pre-write value when a write commits in the same cycle.
  assign rdata    = regs_q[ridx];
  assign wr_stb_o = wr_stb_q;

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < REG_N; i++) begin
      regs_o[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave exposing REG_N full-word registers.
// Ports: ACLK, ARESETn (sync, active-low), s_axi (AXI4-Lite slave modport),
// regs_o (all register contents, reg i at [i*DATA_W +: DATA_W]),
// wr_stb_o (one-hot pulse marking the register just written).
// Write and read FSMs run independently; register index comes from the
// address bits just above the byte offset, upper bits alias.
module axi4_lite_reg_slave
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_N  = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  axi4_lite_if.slave              s_axi,
  output logic [REG_N*DATA_W-1:0] regs_o,
  output logic [REG_N-1:0]        wr_stb_o
);

  localparam int IDX_W    = $clog2(REG_N);
  localparam int ADDR_LSB = $clog2(DATA_W / 8);

  wr_state_e         wr_state_q, wr_state_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic              live_q;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [ADDR_W-1:0] awaddr, araddr;
  logic [IDX_W-1:0]  aw_idx_in, ar_idx_in;
  logic              aw_hs, w_hs, ar_hs;
  logic              awready, wready, bvalid, arready, rvalid;
  logic              we;
  logic [IDX_W-1:0]  widx;
  logic [DATA_W-1:0] wdata, rd_word;
  logic              unused_addr;

  assign awaddr      = s_axi.AWADDR;
  assign araddr      = s_axi.ARADDR;
  assign aw_idx_in   = awaddr[ADDR_LSB +: IDX_W];
  assign ar_idx_in   = araddr[ADDR_LSB +: IDX_W];
  assign unused_addr = ^{awaddr, araddr};

  // Handshakes are qualified by the READY each state presents; live_q keeps
  // every READY low until the first edge with ARESETn high.
  assign aw_hs = s_axi.AWVALID && awready;
  assign w_hs  = s_axi.WVALID  && wready;
  assign ar_hs = s_axi.ARVALID && arready;

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin awready = live_q; wready = live_q; end
      W_ADDR: wready  = live_q;
      W_DATA: awready = live_q;
      W_RESP: bvalid  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    we         = 1'b0;
    widx       = aw_idx_q;
    wdata      = wdata_q;
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          we         = 1'b1;
          widx       = aw_idx_in;
          wdata      = s_axi.WDATA;
          wr_state_d = W_RESP;
        end else if (aw_hs) begin
          aw_idx_d   = aw_idx_in;
          wr_state_d = W_ADDR;
        end else if (w_hs) begin
          wdata_d    = s_axi.WDATA;
          wr_state_d = W_DATA;
        end
      end
      W_ADDR: begin
        if (w_hs) begin
          we         = 1'b1;
          wdata      = s_axi.WDATA;
          wr_state_d = W_RESP;
        end
      end
      W_DATA: begin
        if (aw_hs) begin
          we         = 1'b1;
          widx       = aw_idx_in;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.BREADY) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    arready    = 1'b0;
    rvalid     = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        arready = live_q;
        if (ar_hs) begin
          rdata_d    = rd_word;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (s_axi.RREADY) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      live_q     <= 1'b0;
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      live_q     <= 1'b1;
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign s_axi.AWREADY = awready;
  assign s_axi.WREADY  = wready;
  assign s_axi.BVALID  = bvalid;
  assign s_axi.ARREADY = arready;
  assign s_axi.RVALID  = rvalid;
  assign s_axi.RDATA   = rdata_q;

  axi4_lite_reg_bank #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .IDX_W  (IDX_W)
  ) u_reg_bank (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .we       (we),
    .widx     (widx),
    .wdata    (wdata),
    .ridx     (ar_idx_in),
    .rdata    (rd_word),
    .regs_o   (regs_o),
    .wr_stb_o (wr_stb_o)
  );

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave (32-bit address/data, 16 registers).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_axi4_lite_reg_slave;

  logic         aclk;
  logic         aresetn;
  logic [511:0] regs;
  logic [15:0]  wr_stb;
  int           checks;
  int           failures;

  axi4_lite_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axi4_lite_reg_slave #(.ADDR_W(32), .DATA_W(32), .REG_N(16)) dut (
    .ACLK     (aclk),
    .ARESETn  (aresetn),
    .s_axi    (axi),
    .regs_o   (regs),
    .wr_stb_o (wr_stb)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [31:0] reg_at(input int i);
    return regs[i*32 +: 32];
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    axi.AWVALID = 1'b0; axi.AWADDR = '0;
    axi.WVALID  = 1'b0; axi.WDATA  = '0;
    axi.BREADY  = 1'b0;
    axi.ARVALID = 1'b0; axi.ARADDR = '0;
    axi.RREADY  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    aresetn = 1'b0;
    step(); step(); step();
    checks++; if (axi.AWREADY !== 1'b0 || axi.WREADY !== 1'b0 || axi.ARREADY !== 1'b0) begin failures++; $display("FAIL reset_readys got aw=%b w=%b ar=%b exp 0 0 0", axi.AWREADY, axi.WREADY, axi.ARREADY); end
    checks++; if (axi.BVALID !== 1'b0 || axi.RVALID !== 1'b0) begin failures++; $display("FAIL reset_valids got b=%b r=%b exp 0 0", axi.BVALID, axi.RVALID); end
    checks++; if (axi.RDATA !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", axi.RDATA); end
    checks++; if (regs !== '0 || wr_stb !== 16'h0) begin failures++; $display("FAIL reset_regs got stb=%h regs_nonzero=%b exp 0", wr_stb, |regs); end
    aresetn = 1'b1;
    #1;
    checks++; if (axi.AWREADY !== 1'b0 || axi.ARREADY !== 1'b0) begin failures++; $display("FAIL reset_release_early got aw=%b ar=%b exp 0 0", axi.AWREADY, axi.ARREADY); end
    step();
    checks++; if (axi.AWREADY !== 1'b1 || axi.WREADY !== 1'b1 || axi.ARREADY !== 1'b1) begin failures++; $display("FAIL reset_release got aw=%b w=%b ar=%b exp 1 1 1", axi.AWREADY, axi.WREADY, axi.ARREADY); end
  endtask

  task automatic test_simul_write();
    axi.AWVALID = 1'b1; axi.AWADDR = 32'h08;
    axi.WVALID  = 1'b1; axi.WDATA  = 32'hDEADBEEF;
    step();
    axi.AWVALID = 1'b0; axi.WVALID = 1'b0;
    checks++; if (axi.BVALID !== 1'b1) begin failures++; $display("FAIL simul_bvalid got=%b exp=1", axi.BVALID); end
    checks++; if (wr_stb !== 16'h0004) begin failures++; $display("FAIL simul_stb got=%h exp=0004", wr_stb); end
    checks++; if (reg_at(2) !== 32'hDEADBEEF) begin failures++; $display("FAIL simul_reg2 got=%h exp=deadbeef", reg_at(2)); end
    axi.BREADY = 1'b1;
    step();
    axi.BREADY = 1'b0;
    checks++; if (axi.BVALID !== 1'b0 || wr_stb !== 16'h0) begin failures++; $display("FAIL simul_done got b=%b stb=%h exp 0 0000", axi.BVALID, wr_stb); end
  endtask

  task automatic test_data_first();
    int stb_seen;
    stb_seen = 0;
    axi.WVALID = 1'b1; axi.WDATA = 32'h12345678;
    step();
    axi.WVALID = 1'b0; axi.WDATA = 32'hFFFFFFFF;
    checks++; if (axi.WREADY !== 1'b0 || axi.AWREADY !== 1'b1 || axi.BVALID !== 1'b0) begin failures++; $display("FAIL dfirst_ready got w=%b aw=%b b=%b exp 0 1 0", axi.WREADY, axi.AWREADY, axi.BVALID); end
    step(); step();
    if (wr_stb !== 16'h0) stb_seen++;
    axi.AWVALID = 1'b1; axi.AWADDR = 32'h3C;
    step();
    axi.AWVALID = 1'b0;
    checks++; if (axi.BVALID !== 1'b1 || wr_stb !== 16'h8000) begin failures++; $display("FAIL dfirst_commit got b=%b stb=%h exp 1 8000", axi.BVALID, wr_stb); end
    checks++; if (reg_at(15) !== 32'h12345678 || reg_at(2) !== 32'hDEADBEEF) begin failures++; $display("FAIL dfirst_regs got r15=%h r2=%h exp 12345678 deadbeef", reg_at(15), reg_at(2)); end
    axi.BREADY = 1'b1;
    step();
    axi.BREADY = 1'b0;
    if (wr_stb !== 16'h0 || axi.BVALID !== 1'b0) stb_seen++;
    step();
    if (wr_stb !== 16'h0 || axi.BVALID !== 1'b0) stb_seen++;
    checks++; if (stb_seen !== 0) begin failures++; $display("FAIL dfirst_single got extra_events=%0d exp=0", stb_seen); end
  endtask

  task automatic test_back_pressure();
    axi.AWVALID = 1'b1; axi.AWADDR = 32'h04;
    axi.WVALID  = 1'b1; axi.WDATA  = 32'h11111111;
    step();
    checks++; if (axi.BVALID !== 1'b1 || wr_stb !== 16'h0002 || reg_at(1) !== 32'h11111111) begin failures++; $display("FAIL bp_first got b=%b stb=%h r1=%h exp 1 0002 11111111", axi.BVALID, wr_stb, reg_at(1)); end
    axi.AWADDR = 32'h0C; axi.WDATA = 32'h22222222;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (axi.BVALID !== 1'b1 || axi.AWREADY !== 1'b0 || axi.WREADY !== 1'b0 || wr_stb !== 16'h0 || reg_at(3) !== 32'h0) begin failures++; $display("FAIL bp_hold%0d got b=%b aw=%b w=%b stb=%h r3=%h exp 1 0 0 0000 0", i, axi.BVALID, axi.AWREADY, axi.WREADY, wr_stb, reg_at(3)); end
    end
    axi.BREADY = 1'b1;
    step();
    axi.BREADY = 1'b0;
    checks++; if (axi.BVALID !== 1'b0 || axi.AWREADY !== 1'b1 || reg_at(3) !== 32'h0) begin failures++; $display("FAIL bp_release got b=%b aw=%b r3=%h exp 0 1 0", axi.BVALID, axi.AWREADY, reg_at(3)); end
    step();
    axi.AWVALID = 1'b0; axi.WVALID = 1'b0;
    checks++; if (axi.BVALID !== 1'b1 || wr_stb !== 16'h0008 || reg_at(3) !== 32'h22222222) begin failures++; $display("FAIL bp_second got b=%b stb=%h r3=%h exp 1 0008 22222222", axi.BVALID, wr_stb, reg_at(3)); end
    axi.BREADY = 1'b1;
    step();
    axi.BREADY = 1'b0;
  endtask

  task automatic test_read_stall();
    axi.ARVALID = 1'b1; axi.ARADDR = 32'h48;
    step();
    axi.ARVALID = 1'b0; axi.ARADDR = 32'h3C;
    checks++; if (axi.RVALID !== 1'b1 || axi.ARREADY !== 1'b0 || axi.RDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_first got rv=%b ar=%b rdata=%h exp 1 0 deadbeef", axi.RVALID, axi.ARREADY, axi.RDATA); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (axi.RVALID !== 1'b1 || axi.RDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_stall%0d got rv=%b rdata=%h exp 1 deadbeef", i, axi.RVALID, axi.RDATA); end
    end
    axi.RREADY = 1'b1;
    step();
    axi.RREADY = 1'b0;
    checks++; if (axi.RVALID !== 1'b0 || axi.ARREADY !== 1'b1) begin failures++; $display("FAIL rd_done got rv=%b ar=%b exp 0 1", axi.RVALID, axi.ARREADY); end
  endtask

  task automatic test_read_during_write();
    axi.AWVALID = 1'b1; axi.AWADDR = 32'h14;
    axi.WVALID  = 1'b1; axi.WDATA  = 32'hA5A5A5A5;
    axi.ARVALID = 1'b1; axi.ARADDR = 32'h14;
    step();
    axi.AWVALID = 1'b0; axi.WVALID = 1'b0; axi.ARVALID = 1'b0;
    checks++; if (axi.RVALID !== 1'b1 || axi.RDATA !== 32'h0) begin failures++; $display("FAIL rdw_old got rv=%b rdata=%h exp 1 0", axi.RVALID, axi.RDATA); end
    checks++; if (axi.BVALID !== 1'b1 || reg_at(5) !== 32'hA5A5A5A5 || wr_stb !== 16'h0020) begin failures++; $display("FAIL rdw_write got b=%b r5=%h stb=%h exp 1 a5a5a5a5 0020", axi.BVALID, reg_at(5), wr_stb); end
    axi.BREADY = 1'b1; axi.RREADY = 1'b1;
    step();
    axi.BREADY = 1'b0; axi.RREADY = 1'b0;
    checks++; if (axi.RVALID !== 1'b0 || axi.BVALID !== 1'b0) begin failures++; $display("FAIL rdw_done got rv=%b b=%b exp 0 0", axi.RVALID, axi.BVALID); end
    axi.ARVALID = 1'b1; axi.ARADDR = 32'h14;
    step();
    axi.ARVALID = 1'b0;
    checks++; if (axi.RVALID !== 1'b1 || axi.RDATA !== 32'hA5A5A5A5) begin failures++; $display("FAIL rdw_reread got rv=%b rdata=%h exp 1 a5a5a5a5", axi.RVALID, axi.RDATA); end
    axi.RREADY = 1'b1;
    step();
    axi.RREADY = 1'b0;
  endtask

  task automatic test_reset_midop();
    axi.AWVALID = 1'b1; axi.AWADDR = 32'h00;
    axi.WVALID  = 1'b1; axi.WDATA  = 32'h0F0F0F0F;
    axi.ARVALID = 1'b1; axi.ARADDR = 32'h08;
    step();
    idle_inputs();
    checks++; if (axi.BVALID !== 1'b1 || axi.RVALID !== 1'b1 || axi.RDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL mid_pending got b=%b rv=%b rdata=%h exp 1 1 deadbeef", axi.BVALID, axi.RVALID, axi.RDATA); end
    aresetn = 1'b0;
    step();
    checks++; if (axi.BVALID !== 1'b0 || axi.RVALID !== 1'b0 || axi.RDATA !== 32'h0) begin failures++; $display("FAIL mid_valids got b=%b rv=%b rdata=%h exp 0 0 0", axi.BVALID, axi.RVALID, axi.RDATA); end
    checks++; if (regs !== '0 || wr_stb !== 16'h0) begin failures++; $display("FAIL mid_regs got r0=%h r2=%h stb=%h exp 0 0 0", reg_at(0), reg_at(2), wr_stb); end
    step();
    checks++; if (axi.AWREADY !== 1'b0 || axi.WREADY !== 1'b0 || axi.ARREADY !== 1'b0) begin failures++; $display("FAIL mid_readys got aw=%b w=%b ar=%b exp 0 0 0", axi.AWREADY, axi.WREADY, axi.ARREADY); end
    aresetn = 1'b1;
    step();
    checks++; if (axi.AWREADY !== 1'b1 || axi.WREADY !== 1'b1 || axi.ARREADY !== 1'b1) begin failures++; $display("FAIL mid_release got aw=%b w=%b ar=%b exp 1 1 1", axi.AWREADY, axi.WREADY, axi.ARREADY); end
    // Held write data must be dropped by a reset.
    axi.WVALID = 1'b1; axi.WDATA = 32'h00000077;
    step();
    axi.WVALID = 1'b0;
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    step();
    axi.AWVALID = 1'b1; axi.AWADDR = 32'h00;
    step();
    axi.AWVALID = 1'b0;
    checks++; if (axi.BVALID !== 1'b0 || axi.AWREADY !== 1'b0 || axi.WREADY !== 1'b1 || reg_at(0) !== 32'h0) begin failures++; $display("FAIL mid_abandon got b=%b aw=%b w=%b r0=%h exp 0 0 1 0", axi.BVALID, axi.AWREADY, axi.WREADY, reg_at(0)); end
    axi.WVALID = 1'b1; axi.WDATA = 32'h00000099;
    step();
    axi.WVALID = 1'b0;
    checks++; if (axi.BVALID !== 1'b1 || reg_at(0) !== 32'h00000099 || wr_stb !== 16'h0001) begin failures++; $display("FAIL mid_after got b=%b r0=%h stb=%h exp 1 00000099 0001", axi.BVALID, reg_at(0), wr_stb); end
    axi.BREADY = 1'b1;
    step();
    axi.BREADY = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    aresetn  = 1'b0;
    idle_inputs();
    test_reset();
    test_simul_write();
    test_data_first();
    test_back_pressure();
    test_read_stall();
    test_read_during_write();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_lite_reg_slave.md
AXI4_LITE_REG_SLAVE -- requirements
Module: axi4_lite_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32: AXI data and register width (32 or 64).
REQ-003 SHALL have parameter REG_N, default 16: number of registers (power of 2, >= 2).
REQ-004 SHALL have port ACLK  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port ARESETn  input  1: reset, synchronous, active-low.
REQ-006 SHALL have ports AWVALID in 1, AWREADY out 1, AWADDR in ADDR_W: write address channel.
REQ-007 SHALL have ports WVALID in 1, WREADY out 1, WDATA in DATA_W: write data channel.
REQ-008 SHALL have ports BVALID out 1, BREADY in 1: write response channel.
REQ-009 SHALL have ports ARVALID in 1, ARREADY out 1, ARADDR in ADDR_W: read address channel.
REQ-010 SHALL have ports RVALID out 1, RREADY in 1, RDATA out DATA_W: read data channel.
REQ-011 SHALL have port regs_o  output  REG_N*DATA_W: all register contents; register i at bits [i*DATA_W +: DATA_W].
REQ-012 SHALL have port wr_stb_o  output  REG_N: one-cycle one-hot pulse marking the register just written.
REQ-013 SHALL make the AXI port names and widths match the slave modport of axi4_lite_if; no WSTRB, BRESP, RRESP, PROT.

Function
REQ-014 SHALL decode register index = ADDR[$clog2(DATA_W/8) +: $clog2(REG_N)]; other address bits ignored (aliasing, no error).
REQ-015 SHALL run the write FSM with states W_IDLE, W_ADDR (address held), W_DATA (data held), W_RESP.
REQ-016 SHALL, in W_IDLE, assert AWREADY=1 and WREADY=1; in W_ADDR only WREADY=1; in W_DATA only AWREADY=1; in W_RESP both 0.
REQ-017 SHALL move on handshake: AW only -> W_ADDR, W only -> W_DATA, both same cycle -> W_RESP; W_ADDR+W or W_DATA+AW -> W_RESP.
REQ-018 SHALL write the full word into the register, pulse wr_stb_o and raise BVALID in the cycle after the completing handshake (latency 1).
REQ-019 SHALL hold BVALID=1 until BREADY=1 sampled, then return to W_IDLE; BREADY=1 while BVALID=0 has no effect.
REQ-020 SHALL run the read FSM with states R_IDLE (ARREADY=1, RVALID=0) and R_DATA (ARREADY=0, RVALID=1).
REQ-021 SHALL register RDATA on AR handshake, so RVALID/RDATA appear the cycle after ARVALID&ARREADY (latency 1).
REQ-022 SHALL keep RDATA stable while RVALID=1 and RREADY=0; on RVALID&RREADY return to R_IDLE (no back-to-back read without an idle cycle).
REQ-023 SHALL, when a read handshake and a register write occur in the same cycle on the same index, return the pre-write value.
REQ-024 SHALL operate read and write FSMs fully independently; neither stalls the other.
REQ-025 SHALL never drop VALID or change address/data outputs before the matching READY.

Reset
REQ-026 SHALL, while ARESETn=0 at a rising edge, set all registers to 0, FSMs to W_IDLE/R_IDLE, BVALID=RVALID=0, RDATA=0, wr_stb_o=0.
REQ-027 SHALL drive AWREADY=WREADY=ARREADY=0 during reset; they go to 1 in the first cycle after ARESETn is sampled 1.
REQ-028 SHALL abandon any partial transaction (held address/data, pending B or R) when reset is applied mid-operation.

Structure
REQ-029 SHALL place the write and read FSM state enum typedefs in the shared package axi4_lite_pkg.
REQ-030 SHALL implement the register array plus wr_stb_o generation in one sub-module, axi4_lite_reg_bank (write port, combinational read).

Verification
REQ-031 SHALL check: after reset, AWVALID+WVALID same cycle, AWADDR=0x08, WDATA=0xDEADBEEF -> next cycle BVALID=1, wr_stb_o=0x0004, regs_o reg2=0xDEADBEEF.
REQ-032 SHALL check: WDATA=0x12345678 three cycles before AWADDR=0x3C -> WREADY low after W accepted, single write to reg15, one BVALID.
REQ-033 SHALL check: BREADY held 0 for 5 cycles -> BVALID stays 1, AWREADY=WREADY=0, no second write accepted.
REQ-034 SHALL check: ARADDR=0x48 (aliases reg2) with RREADY=0 for 3 cycles -> RVALID=1, RDATA=0xDEADBEEF stable.
REQ-035 SHALL check: read of reg5 in the write-commit cycle of 0xA5A5A5A5 to reg5 -> RDATA=0, then a re-read returns 0xA5A5A5A5.
REQ-036 SHALL check: ARESETn=0 while BVALID=1 and RVALID=1 -> next cycle both 0, all registers 0, READYs 0 until reset released.
